// File: rtl/cva6_ldbuf_tid_pool.sv
// cva6_ldbuf_tid_pool: load-buffer cache transaction-ID pool with per-load metadata; CVA6_LDBUF_PERF_EN adds occupancy/full-cycle counters
module cva6_ldbuf_tid_pool #(
    parameter int NR_ENTRIES = 8,
    parameter int ID_W       = $clog2(NR_ENTRIES),
    parameter int TRANS_ID_W = 3
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  alloc_req_i,
    output logic                  alloc_gnt_o,
    output logic [ID_W-1:0]       alloc_id_o,
    input  logic [TRANS_ID_W-1:0] alloc_trans_id_i,
    input  logic [2:0]            alloc_offset_i,
    input  logic [1:0]            alloc_size_i,
    input  logic                  alloc_sign_i,
    input  logic                  rsp_valid_i,
    input  logic [ID_W-1:0]       rsp_id_i,
    output logic [TRANS_ID_W-1:0] rsp_trans_id_o,
    output logic [2:0]            rsp_offset_o,
    output logic [1:0]            rsp_size_o,
    output logic                  rsp_sign_o,
    output logic                  rsp_drop_o,
    output logic                  rsp_err_o,
    input  logic                  kill_i,
    output logic                  empty_o,
    output logic                  full_o
`ifdef CVA6_LDBUF_PERF_EN
   ,output logic [ID_W:0]         occupancy_o,
    output logic [31:0]           full_cycles_o
`endif
);
    localparam int MW = TRANS_ID_W + 6;

    typedef enum logic [1:0] {FREE, VALID, KILLED} state_e;

    state_e                state_q [NR_ENTRIES];
    state_e                state_d [NR_ENTRIES];
    logic   [MW-1:0]       meta_q  [NR_ENTRIES];
    logic   [NR_ENTRIES-1:0] free_v;
    state_e                rsp_st;
    logic                  rsp_free;

    always_comb begin
        free_v     = '0;
        alloc_id_o = '0;
        for (int i = NR_ENTRIES - 1; i >= 0; i--) begin
            free_v[i] = state_q[i] == FREE;
            if (free_v[i]) alloc_id_o = ID_W'(i);
        end
    end

    assign empty_o     = &free_v;
    assign full_o      = ~|free_v;
    assign alloc_gnt_o = alloc_req_i & ~full_o;

    assign rsp_st   = state_q[rsp_id_i];
    assign rsp_free = rsp_valid_i & (rsp_st != FREE);
    assign {rsp_trans_id_o, rsp_offset_o, rsp_size_o, rsp_sign_o} = meta_q[rsp_id_i];
    // a same-cycle kill already applies to the entry being answered
    assign rsp_drop_o = rsp_valid_i & ((rsp_st == KILLED) | ((rsp_st == VALID) & kill_i));
    assign rsp_err_o  = rsp_valid_i & (rsp_st == FREE);

    always_comb begin
        state_d = state_q;
        for (int i = 0; i < NR_ENTRIES; i++) begin
            if (kill_i && state_q[i] == VALID) state_d[i] = KILLED;
            if (rsp_free && rsp_id_i == ID_W'(i)) state_d[i] = FREE;
            if (alloc_gnt_o && alloc_id_o == ID_W'(i)) state_d[i] = VALID;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NR_ENTRIES; i++) begin
                state_q[i] <= FREE;
                meta_q[i]  <= '0;
            end
        end else begin
            state_q <= state_d;
            if (alloc_gnt_o) meta_q[alloc_id_o] <= {alloc_trans_id_i, alloc_offset_i, alloc_size_i, alloc_sign_i};
        end
    end

`ifdef CVA6_LDBUF_PERF_EN
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            occupancy_o   <= '0;
            full_cycles_o <= '0;
        end else begin
            occupancy_o   <= occupancy_o + (ID_W+1)'(alloc_gnt_o) - (ID_W+1)'(rsp_free);
            full_cycles_o <= full_cycles_o + 32'(full_o);
        end
    end
`endif

endmodule

// File: tb/tb_cva6_ldbuf_tid_pool.sv
// tb_cva6_ldbuf_tid_pool: directed vector table plus hand-written fill and counter sequences
module tb_cva6_ldbuf_tid_pool;
    logic       clk_i = 0;
    logic       rst_ni = 0;
    logic       alloc_req_i = 0;
    logic       alloc_gnt_o;
    logic [2:0] alloc_id_o;
    logic [2:0] alloc_trans_id_i = 0;
    logic [2:0] alloc_offset_i = 0;
    logic [1:0] alloc_size_i = 0;
    logic       alloc_sign_i = 0;
    logic       rsp_valid_i = 0;
    logic [2:0] rsp_id_i = 0;
    logic [2:0] rsp_trans_id_o;
    logic [2:0] rsp_offset_o;
    logic [1:0] rsp_size_o;
    logic       rsp_sign_o;
    logic       rsp_drop_o;
    logic       rsp_err_o;
    logic       kill_i = 0;
    logic       empty_o;
    logic       full_o;
`ifdef CVA6_LDBUF_PERF_EN
    logic [3:0]  occupancy_o;
    logic [31:0] full_cycles_o;
`endif

    int checks = 0;
    int errors = 0;

    cva6_ldbuf_tid_pool dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .alloc_req_i(alloc_req_i), .alloc_gnt_o(alloc_gnt_o), .alloc_id_o(alloc_id_o),
        .alloc_trans_id_i(alloc_trans_id_i), .alloc_offset_i(alloc_offset_i),
        .alloc_size_i(alloc_size_i), .alloc_sign_i(alloc_sign_i),
        .rsp_valid_i(rsp_valid_i), .rsp_id_i(rsp_id_i),
        .rsp_trans_id_o(rsp_trans_id_o), .rsp_offset_o(rsp_offset_o),
        .rsp_size_o(rsp_size_o), .rsp_sign_o(rsp_sign_o),
        .rsp_drop_o(rsp_drop_o), .rsp_err_o(rsp_err_o),
        .kill_i(kill_i), .empty_o(empty_o), .full_o(full_o)
`ifdef CVA6_LDBUF_PERF_EN
       ,.occupancy_o(occupancy_o), .full_cycles_o(full_cycles_o)
`endif
    );

    always #5 clk_i = ~clk_i;

    typedef struct packed {
        logic       rst, req;
        logic [8:0] md;
        logic       rv;
        logic [2:0] rid;
        logic       kill, gnt;
        logic [2:0] id;
        logic       drop, err, empty, full;
        logic [8:0] emd;
    } vec_t;

    vec_t tbl [35];

    function automatic int m(input int t, input int o, input int s, input int g);
        return (t << 6) | (o << 3) | (s << 1) | g;
    endfunction

    function automatic vec_t mk(input int rst, input int req, input int md, input int rv, input int rid,
                                input int kill, input int gnt, input int id, input int drop, input int err,
                                input int empty, input int full, input int emd);
        vec_t v;
        v.rst = rst[0]; v.req = req[0]; v.md = md[8:0]; v.rv = rv[0]; v.rid = rid[2:0];
        v.kill = kill[0]; v.gnt = gnt[0]; v.id = id[2:0]; v.drop = drop[0]; v.err = err[0];
        v.empty = empty[0]; v.full = full[0]; v.emd = emd[8:0];
        return v;
    endfunction

    task automatic chk(input string nm, input int t, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s step %0d: got %0h want %0h", nm, t, act, exp);
        end
    endtask

    initial begin
        int n;
        //          rst req md              rv rid kill gnt id drop err empty full emd
        tbl[0]  = mk(0, 0, 0,               0, 0, 0,   0, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 8; k++)
            tbl[1+k] = mk(0, 1, m(k, 7-k, k%4, k%2), 0, 0, 0, 1, k, 0, 0, int'(k == 0), 0, 0);
        tbl[9]  = mk(0, 1, m(1,1,1,1),      0, 0, 0,   0, 0, 0, 0, 0, 1, 0);
        tbl[10] = mk(0, 1, 0,               1, 4, 0,   0, 0, 0, 0, 0, 1, m(4,3,0,0));
        tbl[11] = mk(0, 1, m(6,6,3,0),      0, 0, 0,   1, 4, 0, 0, 0, 0, 0);
        tbl[12] = mk(0, 0, 0,               1, 0, 0,   0, 0, 0, 0, 0, 1, m(0,7,0,0));
        tbl[13] = mk(0, 1, m(5,3,2,1),      0, 0, 0,   1, 0, 0, 0, 0, 0, 0);
        tbl[14] = mk(0, 0, 0,               1, 0, 0,   0, 0, 0, 0, 0, 1, m(5,3,2,1));
        tbl[15] = mk(0, 0, 0,               1, 4, 0,   0, 0, 0, 0, 0, 0, m(6,6,3,0));
        tbl[16] = mk(0, 0, 0,               0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
        tbl[17] = mk(1, 0, 0,               0, 0, 0,   0, 0, 0, 0, 1, 0, 0);
        tbl[18] = mk(0, 0, 0,               1, 6, 0,   0, 0, 0, 1, 1, 0, 0);
        tbl[19] = mk(0, 0, 0,               0, 0, 0,   0, 0, 0, 0, 1, 0, 0);
        for (int k = 0; k < 3; k++)
            tbl[20+k] = mk(0, 1, m(2,1,1,0), 0, 0, 0, 1, k, 0, 0, int'(k == 0), 0, 0);
        tbl[23] = mk(0, 0, 0,               0, 0, 1,   0, 3, 0, 0, 0, 0, 0);
        tbl[24] = mk(0, 0, 0,               1, 1, 0,   0, 3, 1, 0, 0, 0, m(2,1,1,0));
        tbl[25] = mk(0, 1, m(3,0,0,1),      0, 0, 0,   1, 1, 0, 0, 0, 0, 0);
        tbl[26] = mk(0, 1, m(7,7,1,1),      0, 0, 1,   1, 3, 0, 0, 0, 0, 0);
        tbl[27] = mk(0, 0, 0,               1, 3, 0,   0, 4, 0, 0, 0, 0, m(7,7,1,1));
        tbl[28] = mk(0, 0, 0,               1, 1, 1,   0, 3, 1, 0, 0, 0, m(3,0,0,1));
        tbl[29] = mk(0, 1, m(4,4,0,0),      0, 0, 0,   1, 1, 0, 0, 0, 0, 0);
        tbl[30] = mk(0, 0, 0,               1, 1, 1,   0, 3, 1, 0, 0, 0, m(4,4,0,0));
        tbl[31] = mk(0, 0, 0,               1, 1, 0,   0, 1, 0, 1, 0, 0, m(4,4,0,0));
        tbl[32] = mk(0, 0, 0,               1, 0, 0,   0, 1, 1, 0, 0, 0, m(2,1,1,0));
        tbl[33] = mk(0, 0, 0,               1, 2, 0,   0, 0, 1, 0, 0, 0, m(2,1,1,0));
        tbl[34] = mk(0, 0, 0,               0, 0, 0,   0, 0, 0, 0, 1, 0, 0);

        repeat (2) @(posedge clk_i);
        for (int t = 0; t < 35; t++) begin
            @(posedge clk_i); #1;
            rst_ni = ~tbl[t].rst;
            alloc_req_i = tbl[t].req;
            {alloc_trans_id_i, alloc_offset_i, alloc_size_i, alloc_sign_i} = tbl[t].md;
            rsp_valid_i = tbl[t].rv;
            rsp_id_i = tbl[t].rid;
            kill_i = tbl[t].kill;
            @(negedge clk_i);
            chk("gnt", t, 32'(alloc_gnt_o), 32'(tbl[t].gnt));
            chk("id", t, 32'(alloc_id_o), 32'(tbl[t].id));
            chk("drop", t, 32'(rsp_drop_o), 32'(tbl[t].drop));
            chk("err", t, 32'(rsp_err_o), 32'(tbl[t].err));
            chk("empty", t, 32'(empty_o), 32'(tbl[t].empty));
            chk("full", t, 32'(full_o), 32'(tbl[t].full));
            if (tbl[t].rv)
                chk("meta", t, 32'({rsp_trans_id_o, rsp_offset_o, rsp_size_o, rsp_sign_o}), 32'(tbl[t].emd));
        end

        @(posedge clk_i); #1;
        {alloc_req_i, rsp_valid_i, kill_i, rst_ni} = 4'b1001;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk_i);
            if (full_o) break;
            n += int'(alloc_gnt_o);
        end
        chk("fill_full", 0, 32'(full_o), 32'd1);
        chk("fill_grants", 0, 32'(n), 32'd8);
        @(posedge clk_i); #1;
        alloc_req_i = 0;

`ifdef CVA6_LDBUF_PERF_EN
        rst_ni = 0; #1;
        chk("occ_rst", 0, 32'(occupancy_o), 32'd0);
        chk("fc_rst", 0, full_cycles_o, 32'd0);
        @(posedge clk_i); #1;
        rst_ni = 1;
        alloc_req_i = 1;
        repeat (3) @(posedge clk_i); #1;
        chk("occ3", 0, 32'(occupancy_o), 32'd3);
        alloc_req_i = 0; rsp_valid_i = 1; rsp_id_i = 1;
        @(posedge clk_i); #1;
        chk("occ2", 0, 32'(occupancy_o), 32'd2);
        alloc_req_i = 1; rsp_id_i = 0;
        @(posedge clk_i); #1;
        chk("occ_net", 0, 32'(occupancy_o), 32'd2);
        rsp_valid_i = 0;
        repeat (6) @(posedge clk_i); #1;
        alloc_req_i = 0;
        chk("occ8", 0, 32'(occupancy_o), 32'd8);
        repeat (3) @(posedge clk_i); #1;
        chk("full_cycles", 0, full_cycles_o, 32'd3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
